ctrl_regseq: RTL

//  Register-file sequencer of the SRC controller; sits directly upstream of the register-file address driver.

---
 rtl/ctrl_pkg.sv | 12 +
 rtl/ctrl_phasecnt.sv | 35 +++
 rtl/ctrl_regseq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared SRC controller types and register-file address width
package ctrl_pkg;

   localparam int CTRL_WIDTH = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_LOAD = 2'd2
   } state_t;

endpackage

// File: rtl/ctrl_phasecnt.sv
// rtl/ctrl_phasecnt.sv - loadable up/down phase counter with terminal-step flag
module ctrl_phasecnt #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             up,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] last_val,
   output logic [WIDTH-1:0] cnt,
   output logic [WIDTH-1:0] cnt_nxt,
   output logic             last
);

   // cnt_nxt is exposed so the owner can register outputs that track the counter
   always_comb begin
      cnt_nxt = cnt;
      if (load)
         cnt_nxt = load_val;
      else if (step)
         cnt_nxt = up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

   assign last = up ? (cnt == last_val) : (cnt == '0);

endmodule

// File: rtl/ctrl_regseq.sv
// rtl/ctrl_regseq.sv - register-file sequencer: turns sample events into INIT/LOAD address phases
module ctrl_regseq
   import ctrl_pkg::*;
#(
   parameter int WIDTH = CTRL_WIDTH,
   parameter int NREG  = 2**WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             smp_in,
   input  logic             smp_req,
   output logic             en_init,
   output logic             en_load,
   output logic             new_smp,
   output logic             out_smp,
   output logic [WIDTH-1:0] result_reg,
   output logic [WIDTH-1:0] error_reg,
   output logic             busy,
   output logic             out_vld,
   output logic             overrun
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(NREG - 1);

   state_t           state;
   state_t           st_nxt;
   logic             pend_in;
   logic             pend_out;
   logic             want_in;
   logic             want_out;
   logic             start_init;
   logic             start_load;
   logic             cnt_load;
   logic             cnt_step;
   logic             cnt_last;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] err_nxt;

   assign want_in  = pend_in | smp_in;
   assign want_out = pend_out | smp_req;
   assign cnt_load = start_init | start_load;
   assign cnt_step = en && (state != ST_IDLE);

   ctrl_phasecnt #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .step     (cnt_step),
      .up       (state == ST_LOAD),
      .load_val (load_val),
      .last_val (LAST),
      .cnt      (cnt),
      .cnt_nxt  (cnt_nxt),
      .last     (cnt_last)
   );

   // Decision point is idle or the final step of a phase; INIT wins so LOAD sees the freshest buffer
   always_comb begin
      st_nxt     = state;
      start_init = 1'b0;
      start_load = 1'b0;
      load_val   = '0;
      if (en && (state == ST_IDLE || cnt_last)) begin
         if (want_in) begin
            st_nxt     = ST_INIT;
            start_init = 1'b1;
            load_val   = LAST;
         end else if (want_out) begin
            st_nxt     = ST_LOAD;
            start_load = 1'b1;
         end else begin
            st_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pend_in  <= 1'b0;
         pend_out <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= st_nxt;
         // a starting phase consumes one request; a second one stays pending
         pend_in  <= start_init ? (pend_in & smp_in) : want_in;
         pend_out <= start_load ? (pend_out & smp_req) : want_out;
         if ((pend_in & smp_in & ~start_init) | (pend_out & smp_req & ~start_load))
            overrun <= 1'b1;
      end
   end

   always_comb begin
      err_nxt = '0;
      if (st_nxt == ST_LOAD)
         err_nxt = cnt_nxt;
      else if (st_nxt == ST_INIT && cnt_nxt != '0)
         err_nxt = cnt_nxt - WIDTH'(1);
   end

   // Outputs are registered from the next state/count so they line up with the phase cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         en_init    <= 1'b0;
         en_load    <= 1'b0;
         new_smp    <= 1'b0;
         out_smp    <= 1'b0;
         busy       <= 1'b0;
         out_vld    <= 1'b0;
         result_reg <= '0;
         error_reg  <= '0;
      end else begin
         en_init    <= (st_nxt == ST_INIT);
         en_load    <= (st_nxt == ST_LOAD);
         new_smp    <= (st_nxt == ST_INIT) && (cnt_nxt == '0);
         out_smp    <= (st_nxt == ST_LOAD) && (cnt_nxt == LAST);
         busy       <= (st_nxt != ST_IDLE);
         out_vld    <= en & out_smp;
         result_reg <= (st_nxt == ST_IDLE) ? '0 : cnt_nxt;
         error_reg  <= err_nxt;
      end
   end

endmodule
